// File: rtl/fp_add_reduce_ctrl.sv
// Streams DATA_W operands through an external FP adder into an ACC_W accumulator and hands back the sum.
// Optional busy-cycle counter (output busy_cycles_o) is built when FP_ADD_REDUCE_CYCLE_CNT_EN is defined.
module fp_add_reduce_ctrl #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              clear_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic [DATA_W-1:0] add_a_o,
   output logic [ACC_W-1:0]  add_b_o,
   input  logic [ACC_W-1:0]  add_result_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ACC_W-1:0]  out_data_o,
   output logic              busy_o,
`ifdef FP_ADD_REDUCE_CYCLE_CNT_EN
   output logic [31:0]       busy_cycles_o,
`endif
   output logic [1:0]        dbg_state_o
);

   // Handshakes: a beat/result transfers on a rising edge where valid and ready are both 1;
   // in_ready_o is high only while accumulating, out_valid_o only while holding a finished result.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [LEN_W-1:0]   r_cnt;
   logic [LEN_W-1:0]   r_len;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;

   state_t             w_state_nxt;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic [LEN_W-1:0]   w_cnt_nxt;
   logic [LEN_W-1:0]   w_len_nxt;
   logic [LEN_W-1:0]   w_cnt_inc;
   logic               w_start_acc;

   assign w_cnt_inc = r_cnt + LEN_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_start_acc = 1'b0;
      if (clear_i) begin
         // Abort wins over start and both handshakes; a beat offered now is dropped.
         w_state_nxt = IDLE;
         w_acc_nxt   = '0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  w_start_acc = 1'b1;
                  w_len_nxt   = len_i;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = (len_i == '0) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (in_valid_i) begin
                  w_acc_nxt = add_result_i;
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == r_len) w_state_nxt = DONE;
               end
            end
            DONE: begin
               if (out_ready_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_len       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_len       <= w_len_nxt;
         r_in_ready  <= (w_state_nxt == ACCUM);
         r_out_valid <= (w_state_nxt == DONE);
         r_busy      <= (w_state_nxt != IDLE);
      end
   end

`ifdef FP_ADD_REDUCE_CYCLE_CNT_EN
   logic [31:0] r_busy_cycles;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_busy_cycles <= '0;
      end else if (w_start_acc) begin
         r_busy_cycles <= '0;
      end else if (r_busy && (r_busy_cycles != 32'hFFFF_FFFF)) begin
         r_busy_cycles <= r_busy_cycles + 32'd1;
      end
   end

   assign busy_cycles_o = r_busy_cycles;
`endif

   assign add_a_o     = in_data_i;
   assign add_b_o     = r_acc;
   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_out_valid;
   assign out_data_o  = r_acc;
   assign busy_o      = r_busy;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_fp_add_reduce_ctrl.sv
// Self-checking bench for fp_add_reduce_ctrl: directed scenarios plus random integer-valued reductions.
module tb_fp_add_reduce_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] len;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [15:0] add_a;
   logic [31:0] add_b;
   logic [31:0] add_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;
   logic [1:0]  dbg_state;
`ifdef FP_ADD_REDUCE_CYCLE_CNT_EN
   logic [31:0] busy_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fp_add_reduce_ctrl dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .clear_i(clear),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .add_a_o(add_a), .add_b_o(add_b), .add_result_i(add_result),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .busy_o(busy),
`ifdef FP_ADD_REDUCE_CYCLE_CNT_EN
      .busy_cycles_o(busy_cycles),
`endif
      .dbg_state_o(dbg_state)
   );

   // ---------------- float helpers (normal numbers and zero only) ----------------
   function automatic real scale2(real m, int e);
      real r = m;
      if (e > 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real f16_to_real(logic [15:0] b);
      real m;
      if (b[14:0] == 15'd0) return 0.0;
      m = scale2(1.0 + real'(b[9:0]) / 1024.0, int'(b[14:10]) - 15);
      return b[15] ? -m : m;
   endfunction

   function automatic real f32_to_real(logic [31:0] b);
      real m;
      if (b[30:0] == 31'd0) return 0.0;
      m = scale2(1.0 + real'(b[22:0]) / 8388608.0, int'(b[30:23]) - 127);
      return b[31] ? -m : m;
   endfunction

   function automatic logic [31:0] real_to_f32(real x);
      logic s;
      int   e;
      real  r;
      logic [22:0] f;
      if (x == 0.0) return 32'd0;
      s = (x < 0.0);
      r = s ? -x : x;
      e = 127;
      while (r >= 2.0) begin r = r / 2.0; e++; end
      while (r < 1.0) begin r = r * 2.0; e--; end
      f = 23'(longint'((r - 1.0) * 8388608.0));
      return {s, 8'(e), f};
   endfunction

   function automatic logic [15:0] real_to_f16(real x);
      logic s;
      int   e;
      real  r;
      logic [9:0] f;
      if (x == 0.0) return 16'd0;
      s = (x < 0.0);
      r = s ? -x : x;
      e = 15;
      while (r >= 2.0) begin r = r / 2.0; e++; end
      while (r < 1.0) begin r = r * 2.0; e--; end
      f = 10'(longint'((r - 1.0) * 1024.0));
      return {s, 5'(e), f};
   endfunction

   // Environment: the external FP16+FP32 adder the controller drives.
   always_comb add_result = real_to_f32(f16_to_real(add_a) + f32_to_real(add_b));

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] l);
      start = 1'b1;
      len   = l;
      step();
      start = 1'b0;
   endtask

   // Offer one beat; it must be accepted this cycle.
   task automatic send_beat(input logic [15:0] d, input string tag);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      check({tag, " add_a"}, 32'(add_a), 32'(d));
      check({tag, " out_valid early"}, 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         check({tag, " gap in_ready"}, 32'(in_ready), 32'd1);
         check({tag, " gap out_valid"}, 32'(out_valid), 32'd0);
         step();
      end
   endtask

   // Reference: expected FP32 sum of integer-valued operands, via queue of integers.
   logic [31:0] exp_q[$];

   initial begin
      int vals[$];
      int sum;
      int l;
      logic [31:0] exp_v;

      rst = 1'b1; start = 1'b0; len = '0; clear = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #3;
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst out_data", out_data, 32'd0);
      step(); step();
      rst = 1'b0;
      step();

      // Four 1.0 beats, no stalls.
      do_start(16'd4);
      check("t1 busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) send_beat(16'h3C00, "t1");
      check("t1 out_valid", 32'(out_valid), 32'd1);
      check("t1 out_data", out_data, 32'h4080_0000);
      check("t1 in_ready done", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t1 idle busy", 32'(busy), 32'd0);
      check("t1 idle out_valid", 32'(out_valid), 32'd0);
`ifdef FP_ADD_REDUCE_CYCLE_CNT_EN
      check("t1 busy_cycles", busy_cycles, 32'd5);
`endif

      // Zero-length reduction.
      do_start(16'd0);
      check("t2 out_valid", 32'(out_valid), 32'd1);
      check("t2 out_data", out_data, 32'd0);
      check("t2 in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t2 idle", 32'(busy), 32'd0);
      check("t2 in_ready idle", 32'(in_ready), 32'd0);

      // Gaps between beats, backpressured result, start ignored in DONE.
      do_start(16'd3);
      idle_cycles(2, "t3"); send_beat(16'h3C00, "t3");
      idle_cycles(2, "t3"); send_beat(16'hBC00, "t3");
      idle_cycles(2, "t3"); send_beat(16'h4000, "t3");
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         len   = 16'd2;
         check("t3 hold out_valid", 32'(out_valid), 32'd1);
         check("t3 hold out_data", out_data, 32'h4000_0000);
         step();
      end
      start = 1'b1;
      out_ready = 1'b1;
      step();
      start = 1'b0;
      out_ready = 1'b0;
      check("t3 start dropped busy", 32'(busy), 32'd0);
      step();
      check("t3 still idle", 32'(busy), 32'd0);

      // Clear collides with the second beat.
      do_start(16'd4);
      send_beat(16'h3C00, "t4");
      in_valid = 1'b1; in_data = 16'h3C00; clear = 1'b1;
      step();
      in_valid = 1'b0; clear = 1'b0;
      check("t4 clear busy", 32'(busy), 32'd0);
      check("t4 clear acc", out_data, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("t4 no out_valid", 32'(out_valid), 32'd0);
         step();
      end
      do_start(16'd1);
      send_beat(16'h3C00, "t4b");
      check("t4b out_valid", 32'(out_valid), 32'd1);
      check("t4b out_data", out_data, 32'h3F80_0000);
      out_ready = 1'b1; step(); out_ready = 1'b0;

      // Asynchronous reset mid-accumulation.
      do_start(16'd4);
      send_beat(16'h4000, "t5");
      send_beat(16'h4000, "t5");
      #2 rst = 1'b1;
      #1;
      check("t5 rst busy", 32'(busy), 32'd0);
      check("t5 rst in_ready", 32'(in_ready), 32'd0);
      check("t5 rst out_valid", 32'(out_valid), 32'd0);
      check("t5 rst out_data", out_data, 32'd0);
      step();
      rst = 1'b0;
      step();
      check("t5 post idle", 32'(busy), 32'd0);
      check("t5 post out_valid", 32'(out_valid), 32'd0);

      // Random reductions of small integer values.
      for (int t = 0; t < 40; t++) begin
         vals.delete();
         l = $urandom_range(0, 6);
         sum = 0;
         for (int i = 0; i < l; i++) begin
            vals.push_back($urandom_range(0, 16) - 8);
            sum += vals[i];
         end
         exp_q.push_back(real_to_f32(real'(sum)));
         do_start(16'(l));
         for (int i = 0; i < l; i++) begin
            idle_cycles($urandom_range(0, 2), "rnd");
            send_beat(real_to_f16(real'(vals[i])), "rnd");
         end
         exp_v = exp_q.pop_front();
         check("rnd out_valid", 32'(out_valid), 32'd1);
         check("rnd out_data", out_data, exp_v);
         for (int i = $urandom_range(0, 2); i > 0; i--) begin
            step();
            check("rnd held", out_data, exp_v);
         end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check("rnd idle", 32'(busy), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fp_add_reduce_ctrl.md
FP_ADD_REDUCE_CTRL -- requirements
Module: fp_add_reduce_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning width of each streamed FP operand (FP16).
REQ-002 SHALL have parameter ACC_W, default 32, meaning width of the accumulator and result (FP32).
REQ-003 SHALL have parameter LEN_W, default 16, meaning width of the reduction-length field.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, meaning reset, asynchronous, active-high.
REQ-006 SHALL have port start_i, input, 1, meaning start-reduction pulse (honoured only in IDLE).
REQ-007 SHALL have port len_i, input, LEN_W, meaning number of operands to reduce; sampled with start_i.
REQ-008 SHALL have port clear_i, input, 1, meaning synchronous abort.
REQ-009 SHALL have ports in_valid_i, input, 1 and in_ready_o, output, 1, meaning the operand-stream handshake.
REQ-010 SHALL have port in_data_i, input, DATA_W, meaning the operand.
REQ-011 SHALL have ports add_a_o, output, DATA_W and add_b_o, output, ACC_W, meaning the adder operand A and operand B.
REQ-012 SHALL have port add_result_i, input, ACC_W, meaning the combinational adder result (FP16+FP32->FP32).
REQ-013 SHALL have ports out_valid_o, output, 1; out_ready_i, input, 1; and out_data_o, output, ACC_W, meaning the result handshake.
REQ-014 SHALL have port busy_o, output, 1, meaning high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-016 In IDLE with start_i=1: SHALL latch len_i, clear acc to +0 (all zeros) and clear beat count; if len_i=0, SHALL go to DONE, else SHALL go to ACCUM.
REQ-017 SHALL ignore start_i in ACCUM and DONE.
REQ-018 SHALL drive in_ready_o=1 only in ACCUM.
REQ-019 SHALL drive add_a_o=in_data_i and add_b_o=acc combinationally at all times.
REQ-020 On an accepted beat (in_valid_i and in_ready_o): SHALL load acc with add_result_i and increment the count by 1, wrapping modulo 2^LEN_W.
REQ-021 On the beat that makes the count equal the latched length: SHALL go to DONE in the next cycle; exactly len beats are consumed.
REQ-022 In ACCUM with in_valid_i=0: SHALL hold acc, count and state.
REQ-023 In DONE: SHALL drive out_valid_o=1 and out_data_o=acc; on out_ready_i=1, SHALL go to IDLE; otherwise SHALL hold.
REQ-024 Latency: out_valid_o SHALL rise 1 cycle after the last accepted beat, or 1 cycle after start_i for len=0.
REQ-025 out_data_o SHALL equal acc in all states.
REQ-026 clear_i in any state SHALL force IDLE, acc=0 and count=0 next cycle, with priority over start_i and over the handshakes; a beat presented in the same cycle SHALL NOT be accumulated.
REQ-027 If start_i and out_ready_i are both high in DONE, SHALL go to IDLE only; the start SHALL be dropped.

Reset
REQ-028 On rst_i=1: SHALL asynchronously set state=IDLE, acc=0, count=0 and latched length=0.
REQ-029 During reset: in_ready_o, out_valid_o and busy_o SHALL be 0 and out_data_o SHALL be 0.
REQ-030 Reset asserted mid-reduction SHALL discard all partial state; no result is emitted.

Configuration
REQ-031 When macro FP_ADD_REDUCE_CYCLE_CNT_EN is defined: SHALL add output busy_cycles_o (32 bits) counting cycles with busy_o=1, saturating at 0xFFFFFFFF, reset to 0 by rst_i and cleared on each accepted start_i.
REQ-032 Without FP_ADD_REDUCE_CYCLE_CNT_EN: the busy_cycles_o port and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-033 Bench SHALL cover: start len=4, four beats of 0x3C00 with no stalls -> out_data_o=0x40800000, out_valid_o 1 cycle after the 4th beat.
REQ-034 Bench SHALL cover: start len=0 -> next cycle DONE, out_data_o=0x00000000, in_ready_o never high.
REQ-035 Bench SHALL cover: len=3, beats 0x3C00, 0xBC00, 0x4000 with 2-cycle in_valid gaps and out_ready_i held 0 for 5 cycles -> out_data_o=0x40000000 held stable until out_ready_i=1, then IDLE.
REQ-036 Bench SHALL cover: clear_i asserted together with the 2nd of 4 beats -> IDLE next cycle, acc=0, no out_valid_o; a new start len=1 with 0x3C00 -> 0x3F800000.
REQ-037 Bench SHALL cover: rst_i pulsed asynchronously mid-ACCUM -> immediate IDLE with all outputs 0; start_i asserted during DONE is ignored.
REQ-038 With FP_ADD_REDUCE_CYCLE_CNT_EN defined, bench SHALL cover: the REQ-033 run -> busy_cycles_o=5 after return to IDLE.
